// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: combines accumulator R0 and operand RX by a 4-bit opcode.
// Result and N/C/Z flags are captured on the rising clock edge.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] R0,
    input  logic [7:0] RX,
    input  logic [3:0] Operacion,
    output logic [7:0] Resultado,
    output logic [2:0] Banderas
);

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_ADD = 4'b1000,
        OP_SUB = 4'b1001,
        OP_SHL = 4'b1010,
        OP_SHR = 4'b1011,
        OP_NOT = 4'b1100,
        OP_AND = 4'b1101,
        OP_OR  = 4'b1110,
        OP_XOR = 4'b1111
    } op_t;

    logic [7:0]  next_res;
    logic        next_c;
    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [15:0] shl_wide;
    logic [15:0] shr_wide;
    logic        shift_big;

    // Shifting through a 16-bit window keeps the last bit shifted out
    // next to the result byte, so C falls out of the same shift.
    always_comb begin
        sum       = {1'b0, R0} + {1'b0, RX};
        diff      = {1'b0, R0} - {1'b0, RX};
        shift_big = (RX > 8'd8);
        shl_wide  = {8'h00, R0} << RX[3:0];
        shr_wide  = {R0, 8'h00} >> RX[3:0];
    end

    always_comb begin
        next_res = Resultado;
        next_c   = 1'b0;
        case (Operacion)
            OP_ADD: begin
                next_res = sum[7:0];
                next_c   = sum[8];
            end
            OP_SUB: begin
                next_res = diff[7:0];
                next_c   = diff[8];
            end
            OP_SHL: begin
                next_res = shift_big ? 8'h00 : shl_wide[7:0];
                next_c   = shift_big ? 1'b0  : shl_wide[8];
            end
            OP_SHR: begin
                next_res = shift_big ? 8'h00 : shr_wide[15:8];
                next_c   = shift_big ? 1'b0  : shr_wide[7];
            end
            OP_NOT:  next_res = ~RX;
            OP_AND:  next_res = R0 & RX;
            OP_OR:   next_res = R0 | RX;
            OP_XOR:  next_res = R0 ^ RX;
            default: begin
                next_res = Resultado;
                next_c   = 1'b0;
            end
        endcase
    end

    // Opcodes with bit 3 clear (NOP and reserved) leave the registers untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Resultado <= '0;
            Banderas  <= '0;
        end else if (Operacion[3]) begin
            Resultado <= next_res;
            Banderas  <= {next_res[7], next_c, (next_res == 8'h00)};
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed vectors push expected results,
// a monitor pops and compares one cycle after each capturing edge.
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] R0;
    logic [7:0] RX;
    logic [3:0] Operacion;
    logic [7:0] Resultado;
    logic [2:0] Banderas;

    typedef struct {
        int         id;
        logic [7:0] res;
        logic [2:0] flg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    alu_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .R0        (R0),
        .RX        (RX),
        .Operacion (Operacion),
        .Resultado (Resultado),
        .Banderas  (Banderas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic rst, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic [2:0] ef);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        Operacion = op;
        R0        = a;
        RX        = b;
        e.id  = vec_id;
        e.res = er;
        e.flg = ef;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: every capturing edge produces one observable output state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (Resultado !== e.res || Banderas !== e.flg) begin
                    errors++;
                    $display("FAIL vec%0d: Resultado/Banderas got %h/%b expected %h/%b",
                             e.id, Resultado, Banderas, e.res, e.flg);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; Operacion = 4'b0000; R0 = 8'h00; RX = 8'h00;

        // reset with ADD applied, then release with NOP
        issue(1'b0, 4'b1000, 8'h05, 8'h03, 8'h00, 3'b000);
        issue(1'b0, 4'b1000, 8'h05, 8'h03, 8'h00, 3'b000);
        issue(1'b1, 4'b0000, 8'h05, 8'h03, 8'h00, 3'b000);

        // R0=5, RX=3 across all ops
        issue(1'b1, 4'b1000, 8'h05, 8'h03, 8'h08, 3'b000);
        issue(1'b1, 4'b1001, 8'h05, 8'h03, 8'h02, 3'b000);
        issue(1'b1, 4'b1010, 8'h05, 8'h03, 8'h28, 3'b000);
        issue(1'b1, 4'b1011, 8'h05, 8'h03, 8'h00, 3'b011);
        issue(1'b1, 4'b1100, 8'h05, 8'h03, 8'hFC, 3'b100);
        issue(1'b1, 4'b1101, 8'h05, 8'h03, 8'h01, 3'b000);
        issue(1'b1, 4'b1110, 8'h05, 8'h03, 8'h07, 3'b000);
        issue(1'b1, 4'b1111, 8'h05, 8'h03, 8'h06, 3'b000);

        // NOP and reserved codes hold
        issue(1'b1, 4'b0000, 8'hAA, 8'h55, 8'h06, 3'b000);
        issue(1'b1, 4'b0101, 8'h12, 8'h34, 8'h06, 3'b000);
        issue(1'b1, 4'b0111, 8'hFF, 8'hFF, 8'h06, 3'b000);

        // arithmetic edges
        issue(1'b1, 4'b1000, 8'hFF, 8'h01, 8'h00, 3'b011);
        issue(1'b1, 4'b1001, 8'h03, 8'h05, 8'hFE, 3'b110);
        issue(1'b1, 4'b1000, 8'h80, 8'h00, 8'h80, 3'b100);
        issue(1'b1, 4'b1001, 8'h07, 8'h07, 8'h00, 3'b001);

        // shift edges
        issue(1'b1, 4'b1010, 8'h81, 8'h01, 8'h02, 3'b010);
        issue(1'b1, 4'b1010, 8'h81, 8'h08, 8'h00, 3'b011);
        issue(1'b1, 4'b1011, 8'h81, 8'h00, 8'h81, 3'b100);
        issue(1'b1, 4'b1011, 8'h81, 8'h09, 8'h00, 3'b001);
        issue(1'b1, 4'b1011, 8'h81, 8'h08, 8'h00, 3'b011);
        issue(1'b1, 4'b1010, 8'h81, 8'h09, 8'h00, 3'b001);
        issue(1'b1, 4'b1010, 8'h81, 8'h00, 8'h81, 3'b100);
        issue(1'b1, 4'b1011, 8'h81, 8'h01, 8'h40, 3'b010);
        issue(1'b1, 4'b1010, 8'h81, 8'hFF, 8'h00, 3'b001);

        // mid-sequence reset
        issue(1'b1, 4'b1000, 8'h05, 8'h03, 8'h08, 3'b000);
        issue(1'b0, 4'b1001, 8'h05, 8'h03, 8'h00, 3'b000);
        issue(1'b1, 4'b1110, 8'h05, 8'h03, 8'h07, 3'b000);
        issue(1'b1, 4'b0000, 8'h00, 8'h00, 8'h07, 3'b000);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
# alu_8bit

Registered 8-bit arithmetic/logic unit of the 8-bit microcontroller datapath. Combines accumulator operand `R0` and register operand `RX` according to a 4-bit operation code. Result and three status flags are captured on the clock edge for the register file and the control unit.

## Interface
- No parameters; data width fixed at 8 bits.
- `clk`  input  1  rising-edge clock for all state
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`
- `R0`  input  8  first operand (accumulator)
- `RX`  input  8  second operand; also the shift amount for shift operations
- `Operacion`  input  4  operation code
- `Resultado`  output  8  registered result
- `Banderas`  output  3  registered flags: [2]=N (result bit 7), [1]=C (carry/borrow/shifted-out bit), [0]=Z (result == 0)

## Operation
- `Operacion` codes, all unsigned modulo 2^8:
  - 0000 NOP: `Resultado` and `Banderas` hold their previous values.
  - 0001–0111: reserved, treated exactly as NOP.
  - 1000 ADD: R0 + RX; C = bit 8 of the 9-bit sum.
  - 1001 SUB: R0 − RX; C = borrow (1 when R0 < RX).
  - 1010 SHL: R0 << RX, zero fill. C = last bit shifted out, i.e. R0[8−RX] for RX in 1..8. C = 0 for RX = 0 and for RX > 8. Result = 0 for RX ≥ 8.
  - 1011 SHR: logical R0 >> RX, zero fill. C = R0[RX−1] for RX in 1..8. C = 0 for RX = 0 and for RX > 8. Result = 0 for RX ≥ 8.
  - 1100 NOT: ~RX, R0 ignored; C = 0.
  - 1101 AND: R0 & RX; C = 0.
  - 1110 OR: R0 | RX; C = 0.
  - 1111 XOR: R0 ^ RX; C = 0.
- For every non-NOP operation, N and Z are derived from the new 8-bit result.
- No X propagation: every input combination yields defined outputs.

## Timing
- Inputs sampled on each rising edge of `clk`. Outputs update on that edge and are valid for the following cycle (latency 1).
- No handshake. A new operation can be issued every cycle.
- Reset: when `rst_n` = 0 at a rising edge, `Resultado` ← 8'h00 and `Banderas` ← 3'b000.
  - Reset overrides any operation presented in the same cycle.
  - Reset during a sequence discards that cycle's operation. The first operation after deassertion appears one cycle later.
- Outputs are stable between edges; operand or opcode changes between edges have no effect until the next edge.

## Test plan
- Reset then hold: assert `rst_n`=0 with ADD applied -> `Resultado`=00, `Banderas`=000. Release with Operacion=0000 -> outputs stay 00/000.
- R0=5, RX=3, one op per cycle, checking each result one cycle after its edge:
  - ADD -> 08/000
  - SUB -> 02/000
  - SHL -> 28/000
  - SHR -> 00/011
  - NOT -> FC/100
  - AND -> 01/000
  - OR -> 07/000
  - XOR -> 06/000
- Arithmetic edges:
  - R0=FF, RX=01, ADD -> 00/011
  - R0=03, RX=05, SUB -> FE/110
  - R0=80, RX=00, ADD -> 80/100
- Shift edges, R0=81:
  - SHL by 1 -> 02/010
  - SHL by 8 -> 00/011
  - SHR by 0 -> 81/100
  - SHR by 9 -> 00/001
- NOP/reserved hold: after XOR gives 06/000, apply 0000 then 0101 with changed operands -> outputs remain 06/000.
- Mid-sequence reset: ADD cycle, then `rst_n`=0 with SUB applied -> 00/000. Release with OR (5|3) -> 07/000 one cycle later.
